rename_reg_file: RTL and testbench
==================================

Name: rename_reg_file

Overview:
- Architectural register file with per-register rename tags (ROB indices) for the out-of-order core.
- Generalises the single-issue, two-source file: parametrised data width, tag width and number of read channels.
- Adds the sequential behaviour the earlier file lacked:
  - rename-tag allocation at issue;
  - tag-matched retirement at commit;
  - global tag flush on branch mispredict.
- Sits between decoder/issue (source lookup, dest rename) and ROB (commit, flush).

Parameters:
- XLEN, 32, data width of each architectural register.
- TAG_W, 4, ROB tag width. Tag value 0 means "not renamed"; ROB entries are numbered 1..2^TAG_W-1.
- NUM_RD, 2, number of independent combinational read channels (sources per issue).

Ports:
- clk  input  1  clock.
- rst  input  1  Synchronous, active-high reset.
- rdy  input  1  Global ready. When low, all state holds.
- rd_valid  input  NUM_RD  per-channel source-valid.
- rd_addr  input  NUM_RD*5  packed source register indices; channel k occupies bits [5k+4:5k].
- rd_val  output  NUM_RD*XLEN  packed operand values.
- rd_tag  output  NUM_RD*TAG_W  packed pending ROB tags; 0 means the value is ready.
- iss_valid  input  1  rename request this cycle.
- iss_dest  input  5  destination register being renamed.
- iss_tag  input  TAG_W  ROB tag assigned to the destination; must be nonzero.
- com_valid  input  1  commit this cycle.
- com_dest  input  5  committed destination register.
- com_value  input  XLEN  committed result.
- com_tag  input  TAG_W  ROB tag of the committing entry.
- flush  input  1  mispredict. Discards all pending renames.

Behaviour:
- State: val[0..31] (XLEN bits each) and tag[0..31] (TAG_W bits each).
- Register 0 is hardwired:
  - val[0] reads 0 and tag[0] reads 0 at all times;
  - writes and renames to index 0 are ignored.
- Reset (rst=1 at posedge): all val and all tag cleared to 0. rst has priority over rdy.
- Read channels are purely combinational, no latency. Per channel k:
  - rd_valid[k]=0 → rd_val=0, rd_tag=0.
  - Else if tag[a]==0 → rd_val=val[a], rd_tag=0.
  - Else if com_valid && com_tag==tag[a] → rd_val=com_value, rd_tag=0 (commit bypass).
  - Else → rd_val=0, rd_tag=tag[a].
  - Reads never observe the same-cycle iss_* rename, because an instruction's sources precede its own destination.
  - Reads do not depend on rdy or flush.
- Sequential update at posedge, only when rdy=1 and rst=0:
  - Commit (com_valid, com_dest≠0): val[com_dest] <= com_value. Then tag[com_dest] <= 0, but only if tag[com_dest]==com_tag; otherwise a younger rename is kept.
  - Issue (iss_valid, iss_dest≠0, flush=0): tag[iss_dest] <= iss_tag.
  - Same-cycle issue and commit to the same dest: the issue tag wins over the clear; the commit value is still written.
  - Flush: every tag <= 0 and issue is ignored. A same-cycle commit still writes its value (the commit is older than the flush point).
- rdy=0: no state changes. Read outputs remain valid from the held state.
- No internal FSM beyond per-register tag state: each tag[i] is either CLEAN (0) or RENAMED(t).
  - CLEAN→RENAMED on issue.
  - RENAMED(t)→RENAMED(t') on re-issue.
  - RENAMED(t)→CLEAN on matching commit or on flush.

Test Plan:
- Reset then read x5,x0 → rd_val={0,0}, rd_tag={0,0}. Commit x5=0xDEADBEEF tag0 → next cycle read x5=0xDEADBEEF, tag 0.
- Issue x3 tag 4 → next cycle read x3 gives tag 4, val 0. Commit x3=0x11 tag 4 in the same cycle as the read → bypass gives val 0x11, tag 0. Next cycle tag[3]=0, val 0x11.
- Issue x7 tag 2, then issue x7 tag 6, then commit x7=0x55 tag 2 → val[7]=0x55 and tag stays 6. Commit tag 6 value 0x66 → clean, 0x66.
- Same cycle: issue x9 tag 5 and commit x9=0x9 tag 3 (tag[9]=3 before) → tag[9]=5, val[9]=0x9.
- Tags pending on x1,x2 (tags 1,2), then flush with simultaneous commit x1=0xA tag 1 and issue x4 tag 7 → all tags 0, val[1]=0xA, x4 not renamed.
- With rdy=0: issue, commit and flush are all asserted → no state change. Issue/commit to x0 with rdy=1 → x0 reads 0, tag 0.

Source files
------------

// File: rtl/rename_reg_file.sv
// -----------------------------------------------------------------------------
// rename_reg_file
//
// Architectural register file (x0..x31) with a rename tag per register.
// A tag holds the ROB index of the in-flight instruction that will produce
// the register's next value; tag 0 means the stored value is current.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (rst beats rdy)
//   rdy             global ready; when low no state changes
//   rd_valid        per-channel source valid          [NUM_RD]
//   rd_addr         packed source indices, 5 bits/ch  [NUM_RD*5]
//   rd_val          packed operand values             [NUM_RD*XLEN]
//   rd_tag          packed pending tags (0 = ready)   [NUM_RD*TAG_W]
//   iss_valid/dest/tag               rename of a destination at issue
//   com_valid/dest/value/tag         retirement of a ROB entry
//   flush           mispredict: drop every pending rename
//
// Reads are combinational and include a commit bypass: a source waiting on
// the tag that is retiring this very cycle sees the retiring value directly.
// -----------------------------------------------------------------------------
module rename_reg_file #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int NUM_RD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [NUM_RD-1:0]       rd_valid,
  input  logic [NUM_RD*5-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]  rd_val,
  output logic [NUM_RD*TAG_W-1:0] rd_tag,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_dest,
  input  logic [TAG_W-1:0]        iss_tag,
  input  logic                    com_valid,
  input  logic [4:0]              com_dest,
  input  logic [XLEN-1:0]         com_value,
  input  logic [TAG_W-1:0]        com_tag,
  input  logic                    flush
);

  logic [XLEN-1:0]  r_val [32];
  logic [TAG_W-1:0] r_tag [32];

  logic w_com_wr;
  logic w_iss_wr;

  // x0 is never a target; its entry stays at its reset value of zero.
  assign w_com_wr = com_valid && (com_dest != 5'd0);
  assign w_iss_wr = iss_valid && (iss_dest != 5'd0) && !flush;

  // NOTE: this storage is built from flops, not a RAM macro, because reset
  // must clear every value and every tag in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      if (w_com_wr) begin
        r_val[com_dest] <= com_value;
        // Only retire the rename if no younger instruction has re-renamed it.
        if (r_tag[com_dest] == com_tag) begin
          r_tag[com_dest] <= '0;
        end
      end
      // NOTE: with non-blocking assignments the last one in program order
      // wins, so the flush and issue writes below override the commit clear.
      if (flush) begin
        for (int i = 0; i < 32; i++) begin
          r_tag[i] <= '0;
        end
      end else if (w_iss_wr) begin
        r_tag[iss_dest] <= iss_tag;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [4:0]       w_addr;
    logic [TAG_W-1:0] w_tag;
    logic [XLEN-1:0]  w_val;
    logic             w_bypass;

    assign w_addr   = rd_addr[5*k +: 5];
    assign w_tag    = (w_addr == 5'd0) ? '0 : r_tag[w_addr];
    assign w_val    = (w_addr == 5'd0) ? '0 : r_val[w_addr];
    // w_tag is nonzero whenever this matters, so a tag-0 commit never bypasses.
    assign w_bypass = com_valid && (com_tag == w_tag);

    assign rd_val[k*XLEN +: XLEN] =
        !rd_valid[k]     ? '0 :
        (w_tag == '0)    ? w_val :
        w_bypass         ? com_value : '0;

    assign rd_tag[k*TAG_W +: TAG_W] =
        (!rd_valid[k] || (w_tag == '0) || w_bypass) ? '0 : w_tag;
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// -----------------------------------------------------------------------------
// tb_rename_reg_file
//
// Directed scenarios with hand-computed expectations, followed by random
// traffic. A reference model (value and tag arrays updated by the rename /
// retire / flush rules) predicts every read channel; one compare process
// checks all channels on each falling edge.
// -----------------------------------------------------------------------------
module tb_rename_reg_file;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  localparam int NUM_RD = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rdy;
  logic [NUM_RD-1:0]       rd_valid;
  logic [NUM_RD*5-1:0]     rd_addr;
  logic [NUM_RD*XLEN-1:0]  rd_val;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  logic                    iss_valid;
  logic [4:0]              iss_dest;
  logic [TAG_W-1:0]        iss_tag;
  logic                    com_valid;
  logic [4:0]              com_dest;
  logic [XLEN-1:0]         com_value;
  logic [TAG_W-1:0]        com_tag;
  logic                    flush;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference state.
  logic [XLEN-1:0]  m_val [32];
  logic [TAG_W-1:0] m_tag [32];

  rename_reg_file #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_val    (rd_val),
    .rd_tag    (rd_tag),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_tag   (iss_tag),
    .com_valid (com_valid),
    .com_dest  (com_dest),
    .com_value (com_value),
    .com_tag   (com_tag),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update: what the file must hold after this edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] <= '0;
        m_tag[i] <= '0;
      end
    end else if (rdy) begin
      if (com_valid && com_dest != 0) begin
        m_val[com_dest] <= com_value;
        if (m_tag[com_dest] == com_tag) m_tag[com_dest] <= '0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_tag[i] <= '0;
      end else if (iss_valid && iss_dest != 0) begin
        m_tag[iss_dest] <= iss_tag;
      end
    end
  end

  // Compare process: every read channel, every cycle once reset has run.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NUM_RD; k++) begin
        int               a;
        logic [XLEN-1:0]  ev;
        logic [TAG_W-1:0] et;
        a  = int'(rd_addr[5*k +: 5]);
        ev = '0;
        et = '0;
        if (rd_valid[k] && a != 0) begin
          if (m_tag[a] == 0)                            ev = m_val[a];
          else if (com_valid && com_tag == m_tag[a])    ev = com_value;
          else                                          et = m_tag[a];
        end
        check($sformatf("model rd_val[%0d] x%0d", k, a), 64'(rd_val[k*XLEN +: XLEN]), 64'(ev));
        check($sformatf("model rd_tag[%0d] x%0d", k, a), 64'(rd_tag[k*TAG_W +: TAG_W]), 64'(et));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_dest = '0; iss_tag = '0;
    com_valid = 1'b0; com_dest = '0; com_value = '0; com_tag = '0;
    flush = 1'b0;
  endtask

  task automatic reads(input logic [4:0] a0, input logic [4:0] a1);
    rd_valid = 2'b11;
    rd_addr  = {a1, a0};
  endtask

  task automatic issue(input logic [4:0] d, input logic [TAG_W-1:0] t);
    iss_valid = 1'b1; iss_dest = d; iss_tag = t;
  endtask

  task automatic commit(input logic [4:0] d, input logic [XLEN-1:0] v, input logic [TAG_W-1:0] t);
    com_valid = 1'b1; com_dest = d; com_value = v; com_tag = t;
  endtask

  // Literal expectation on one channel, taken at the falling edge.
  task automatic lit(input string name, input int k, input logic [XLEN-1:0] v, input logic [TAG_W-1:0] t);
    check({name, " val"}, 64'(rd_val[k*XLEN +: XLEN]), 64'(v));
    check({name, " tag"}, 64'(rd_tag[k*TAG_W +: TAG_W]), 64'(t));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
    rst = 1'b1; rdy = 1'b1; rd_valid = '0; rd_addr = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    reads(5'd5, 5'd0);
    @(negedge clk); lit("reset x5", 0, 32'h0, 4'h0); lit("reset x0", 1, 32'h0, 4'h0);
    commit(5'd5, 32'hDEADBEEF, 4'd0);
    tick(); idle();
    @(negedge clk); lit("commit x5", 0, 32'hDEADBEEF, 4'h0);
    rd_valid = 2'b00;
    @(negedge clk); lit("rd_valid=0", 0, 32'h0, 4'h0);

    // Rename, bypass, retire.
    reads(5'd3, 5'd5);
    issue(5'd3, 4'd4);
    tick(); idle();
    @(negedge clk); lit("x3 renamed", 0, 32'h0, 4'd4);
    tick();
    commit(5'd3, 32'h11, 4'd4);
    @(negedge clk); lit("x3 bypass", 0, 32'h11, 4'd0);
    tick(); idle();
    @(negedge clk); lit("x3 retired", 0, 32'h11, 4'd0);

    // Younger rename survives an older commit.
    reads(5'd7, 5'd0);
    issue(5'd7, 4'd2); tick();
    issue(5'd7, 4'd6); tick(); idle();
    commit(5'd7, 32'h55, 4'd2); tick(); idle();
    @(negedge clk); lit("x7 keeps tag 6", 0, 32'h0, 4'd6);
    tick();
    commit(5'd7, 32'h66, 4'd6);
    @(negedge clk); lit("x7 bypass 66", 0, 32'h66, 4'd0);
    tick(); idle();
    @(negedge clk); lit("x7 clean", 0, 32'h66, 4'd0);

    // Same-cycle issue and commit to one destination.
    reads(5'd9, 5'd0);
    issue(5'd9, 4'd3); tick(); idle();
    issue(5'd9, 4'd5); commit(5'd9, 32'h9, 4'd3); tick(); idle();
    @(negedge clk); lit("x9 issue wins", 0, 32'h0, 4'd5);

    // Flush with simultaneous commit and issue.
    issue(5'd1, 4'd1); tick();
    issue(5'd2, 4'd2); tick(); idle();
    flush = 1'b1; commit(5'd1, 32'hA, 4'd1); issue(5'd4, 4'd7);
    tick(); idle();
    reads(5'd1, 5'd2);
    @(negedge clk); lit("flush x1", 0, 32'hA, 4'd0); lit("flush x2", 1, 32'h0, 4'd0);
    tick();
    reads(5'd4, 5'd9);
    @(negedge clk); lit("flush x4", 0, 32'h0, 4'd0); lit("flush x9", 1, 32'h9, 4'd0);

    // rdy=0 freezes everything.
    issue(5'd2, 4'd2); tick(); idle();
    rdy = 1'b0;
    issue(5'd6, 4'd3); commit(5'd5, 32'h123, 4'd0); flush = 1'b1;
    tick(); idle(); rdy = 1'b1;
    reads(5'd2, 5'd5);
    @(negedge clk); lit("hold x2", 0, 32'h0, 4'd2); lit("hold x5", 1, 32'hDEADBEEF, 4'd0);
    tick();
    reads(5'd6, 5'd5);
    @(negedge clk); lit("hold x6", 0, 32'h0, 4'd0);

    // x0 ignores rename and commit.
    issue(5'd0, 4'd3); commit(5'd0, 32'hFF, 4'd0);
    tick(); idle();
    reads(5'd0, 5'd0);
    @(negedge clk); lit("x0 ch0", 0, 32'h0, 4'd0); lit("x0 ch1", 1, 32'h0, 4'd0);
    tick();

    // Random traffic on a small register window to force collisions.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] d;
      rst       = ($urandom_range(0, 299) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rd_valid  = NUM_RD'($urandom);
      rd_addr   = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      iss_valid = $urandom_range(0, 1) == 1;
      iss_dest  = 5'($urandom_range(0, 9));
      iss_tag   = TAG_W'($urandom_range(1, 15));
      d         = 5'($urandom_range(0, 9));
      com_valid = $urandom_range(0, 1) == 1;
      com_dest  = d;
      com_value = $urandom;
      com_tag   = ($urandom_range(0, 2) != 0) ? m_tag[d] : TAG_W'($urandom_range(1, 15));
      tick();
    end
    rst = 1'b0; rdy = 1'b1; idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
